// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write scheduler.
// Grant encoding doubles as the one-hot bit index of each requester.
package regfile_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 32;

  localparam logic [ADDR_WIDTH-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_MEM = 1'b1
  } grant_e;

endpackage

// File: rtl/regfile_write_scheduler_rr_arbiter2.sv
// Two-requester round-robin arbiter with a one-hot grant.
// Bit 0 is the ALU, bit 1 is the load unit.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  grant_e last_q, last_d;

  always_comb begin
    gnt_o  = 2'b00;
    last_d = last_q;
    unique case (1'b1)
      (req_i == 2'b11):
        gnt_o = (last_q == GRANT_MEM) ? 2'b01 : 2'b10;
      (req_i == 2'b01): gnt_o = 2'b01;
      (req_i == 2'b10): gnt_o = 2'b10;
      default:          gnt_o = 2'b00;
    endcase
    // A grant is always a transfer: Ready follows grant.
    if (gnt_o[0]) last_d = GRANT_ALU;
    if (gnt_o[1]) last_d = GRANT_MEM;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= GRANT_MEM;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Shares the register-file write port between ALU and load writeback
// and tracks outstanding destination registers in a scoreboard.
module regfile_write_scheduler
  import regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  AluWbValid,
  input  logic [ADDR_WIDTH-1:0] AluWbReg,
  input  logic [DATA_WIDTH-1:0] AluWbData,
  output logic                  AluWbReady,
  input  logic                  MemWbValid,
  input  logic [ADDR_WIDTH-1:0] MemWbReg,
  input  logic [DATA_WIDTH-1:0] MemWbData,
  output logic                  MemWbReady,
  input  logic                  IssueValid,
  input  logic [ADDR_WIDTH-1:0] IssueReg,
  output logic                  IssueReady,
  input  logic [ADDR_WIDTH-1:0] ReadRegister1,
  input  logic [ADDR_WIDTH-1:0] ReadRegister2,
  output logic                  Stall1,
  output logic                  Stall2,
  output logic [ADDR_WIDTH-1:0] WriteReg,
  output logic [DATA_WIDTH-1:0] WriteData,
  output logic                  RegWriteActive
);

  logic [1:0]            gnt;
  logic                  xfer;
  logic [ADDR_WIDTH-1:0] wb_reg;
  logic [DATA_WIDTH-1:0] wb_data;

  logic [ADDR_WIDTH-1:0] wreg_q, wreg_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wact_q, wact_d;
  logic [NUM_REGS-1:0]   pend_q, pend_d;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i ({MemWbValid, AluWbValid}),
    .gnt_o (gnt)
  );

  assign AluWbReady = gnt[GRANT_ALU];
  assign MemWbReady = gnt[GRANT_MEM];
  assign xfer       = |gnt;
  assign wb_reg     = gnt[GRANT_MEM] ? MemWbReg  : AluWbReg;
  assign wb_data    = gnt[GRANT_MEM] ? MemWbData : AluWbData;

  assign IssueReady = !pend_q[IssueReg];
  assign Stall1     = pend_q[ReadRegister1];
  assign Stall2     = pend_q[ReadRegister2];

  always_comb begin
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    wact_d  = 1'b0;
    pend_d  = pend_q;
    // R0 writes are accepted but swallowed here.
    if (xfer && wb_reg != REG_ZERO) begin
      wreg_d  = wb_reg;
      wdata_d = wb_data;
      wact_d  = 1'b1;
    end
    if (xfer) pend_d[wb_reg] = 1'b0;
    if (IssueValid && IssueReady && IssueReg != REG_ZERO)
      pend_d[IssueReg] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wreg_q  <= '0;
      wdata_q <= '0;
      wact_q  <= 1'b0;
      pend_q  <= '0;
    end else begin
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      wact_q  <= wact_d;
      pend_q  <= pend_d;
    end
  end

  assign WriteReg       = wreg_q;
  assign WriteData      = wdata_q;
  assign RegWriteActive = wact_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed vector bench for regfile_write_scheduler.
// Table of cycle records plus hand sequences for reset corner cases.
module tb_regfile_write_scheduler;

  logic        clk;
  logic        rst_n;
  logic        AluWbValid;
  logic [4:0]  AluWbReg;
  logic [31:0] AluWbData;
  logic        AluWbReady;
  logic        MemWbValid;
  logic [4:0]  MemWbReg;
  logic [31:0] MemWbData;
  logic        MemWbReady;
  logic        IssueValid;
  logic [4:0]  IssueReg;
  logic        IssueReady;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic        Stall1;
  logic        Stall2;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic        RegWriteActive;

  int n_chk;
  int n_fail;

  regfile_write_scheduler dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .AluWbValid     (AluWbValid),
    .AluWbReg       (AluWbReg),
    .AluWbData      (AluWbData),
    .AluWbReady     (AluWbReady),
    .MemWbValid     (MemWbValid),
    .MemWbReg       (MemWbReg),
    .MemWbData      (MemWbData),
    .MemWbReady     (MemWbReady),
    .IssueValid     (IssueValid),
    .IssueReg       (IssueReg),
    .IssueReady     (IssueReady),
    .ReadRegister1  (ReadRegister1),
    .ReadRegister2  (ReadRegister2),
    .Stall1         (Stall1),
    .Stall2         (Stall2),
    .WriteReg       (WriteReg),
    .WriteData      (WriteData),
    .RegWriteActive (RegWriteActive)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  mr;
    logic [31:0] md;
    logic        iv;
    logic [4:0]  ir;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        e_ardy;
    logic        e_mrdy;
    logic        e_irdy;
    logic        e_s1;
    logic        e_s2;
    logic        e_wact;
    logic [4:0]  e_wreg;
    logic [31:0] e_wdata;
    logic        e_ps1;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    AluWbValid    = 1'b0;
    AluWbReg      = '0;
    AluWbData     = '0;
    MemWbValid    = 1'b0;
    MemWbReg      = '0;
    MemWbData     = '0;
    IssueValid    = 1'b0;
    IssueReg      = '0;
    ReadRegister1 = '0;
    ReadRegister2 = '0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;

    //        alu                    mem                       iss    rd       ardy mrdy irdy s1 s2  wact wreg wdata         ps1
    vecs[0]  = '{1, 4,  32'h112,       1, 7, 32'h55,       0, 0,  0, 0,  1, 0, 1, 0, 0,  1, 4,  32'h112,       0};
    vecs[1]  = '{1, 5,  32'h33,        1, 7, 32'h55,       0, 0,  0, 0,  0, 1, 1, 0, 0,  1, 7,  32'h55,        0};
    vecs[2]  = '{1, 5,  32'h33,        0, 0, 32'h0,        0, 0,  0, 0,  1, 0, 1, 0, 0,  1, 5,  32'h33,        0};
    vecs[3]  = '{0, 0,  32'h0,         0, 0, 32'h0,        1, 16, 16, 0, 0, 0, 1, 0, 0,  0, 5,  32'h33,        1};
    vecs[4]  = '{1, 16, 32'h8000_0000, 0, 0, 32'h0,        0, 0,  16, 0, 1, 0, 1, 1, 0,  1, 16, 32'h8000_0000, 0};
    vecs[5]  = '{0, 0,  32'h0,         0, 0, 32'h0,        0, 0,  16, 0, 0, 0, 1, 0, 0,  0, 16, 32'h8000_0000, 0};
    vecs[6]  = '{0, 0,  32'h0,         1, 0, 32'hFFFF_FFFF, 0, 0,  0, 0,  0, 1, 1, 0, 0,  0, 16, 32'h8000_0000, 0};
    vecs[7]  = '{0, 0,  32'h0,         0, 0, 32'h0,        1, 0,  0, 0,  0, 0, 1, 0, 0,  0, 16, 32'h8000_0000, 0};
    vecs[8]  = '{0, 0,  32'h0,         0, 0, 32'h0,        1, 9,  9, 0,  0, 0, 1, 0, 0,  0, 16, 32'h8000_0000, 1};
    vecs[9]  = '{0, 0,  32'h0,         0, 0, 32'h0,        1, 9,  9, 9,  0, 0, 0, 1, 1,  0, 16, 32'h8000_0000, 1};
    vecs[10] = '{1, 9,  32'hDEAD_BEEF, 0, 0, 32'h0,        0, 0,  9, 0,  1, 0, 1, 1, 0,  1, 9,  32'hDEAD_BEEF, 0};
    vecs[11] = '{0, 0,  32'h0,         0, 0, 32'h0,        0, 0,  9, 0,  0, 0, 1, 0, 0,  0, 9,  32'hDEAD_BEEF, 0};

    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset RegWriteActive", {31'd0, RegWriteActive}, 32'd0);
    chk("reset WriteReg", {27'd0, WriteReg}, 32'd0);
    chk("reset WriteData", WriteData, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      AluWbValid    = vecs[i].av;
      AluWbReg      = vecs[i].ar;
      AluWbData     = vecs[i].ad;
      MemWbValid    = vecs[i].mv;
      MemWbReg      = vecs[i].mr;
      MemWbData     = vecs[i].md;
      IssueValid    = vecs[i].iv;
      IssueReg      = vecs[i].ir;
      ReadRegister1 = vecs[i].r1;
      ReadRegister2 = vecs[i].r2;
      #1;
      chk($sformatf("v%0d AluWbReady", i), {31'd0, AluWbReady}, {31'd0, vecs[i].e_ardy});
      chk($sformatf("v%0d MemWbReady", i), {31'd0, MemWbReady}, {31'd0, vecs[i].e_mrdy});
      chk($sformatf("v%0d IssueReady", i), {31'd0, IssueReady}, {31'd0, vecs[i].e_irdy});
      chk($sformatf("v%0d Stall1", i), {31'd0, Stall1}, {31'd0, vecs[i].e_s1});
      chk($sformatf("v%0d Stall2", i), {31'd0, Stall2}, {31'd0, vecs[i].e_s2});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d RegWriteActive", i), {31'd0, RegWriteActive}, {31'd0, vecs[i].e_wact});
      chk($sformatf("v%0d WriteReg", i), {27'd0, WriteReg}, {27'd0, vecs[i].e_wreg});
      chk($sformatf("v%0d WriteData", i), WriteData, vecs[i].e_wdata);
      chk($sformatf("v%0d Stall1 post", i), {31'd0, Stall1}, {31'd0, vecs[i].e_ps1});
    end

    // MEM write to R6 while reserving R5; last grant becomes MEM.
    @(negedge clk);
    idle();
    MemWbValid = 1'b1;
    MemWbReg   = 5'd6;
    MemWbData  = 32'h66;
    IssueValid = 1'b1;
    IssueReg   = 5'd5;
    #1;
    chk("s1 MemWbReady", {31'd0, MemWbReady}, 32'd1);
    chk("s1 IssueReady", {31'd0, IssueReady}, 32'd1);
    @(posedge clk);
    #1;
    chk("s1 WriteReg", {27'd0, WriteReg}, 32'd6);

    // Tie with last grant MEM: ALU wins, MEM to R5 stalls.
    @(negedge clk);
    idle();
    AluWbValid    = 1'b1;
    AluWbReg      = 5'd2;
    AluWbData     = 32'h22;
    MemWbValid    = 1'b1;
    MemWbReg      = 5'd5;
    MemWbData     = 32'h77;
    ReadRegister1 = 5'd5;
    #1;
    chk("s2 AluWbReady", {31'd0, AluWbReady}, 32'd1);
    chk("s2 MemWbReady", {31'd0, MemWbReady}, 32'd0);
    chk("s2 Stall1 R5", {31'd0, Stall1}, 32'd1);
    @(posedge clk);
    #1;
    chk("s2 WriteReg", {27'd0, WriteReg}, 32'd2);
    chk("s2 WriteData", WriteData, 32'h22);

    // Reset mid-cycle with the MEM request still pending.
    @(negedge clk);
    AluWbValid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst RegWriteActive", {31'd0, RegWriteActive}, 32'd0);
    chk("rst WriteReg", {27'd0, WriteReg}, 32'd0);
    chk("rst WriteData", WriteData, 32'd0);
    for (int a = 0; a < 32; a++) begin
      ReadRegister1 = a[4:0];
      ReadRegister2 = 5'(31 - a);
      #0.1;
      chk($sformatf("rst Stall1 R%0d", a), {31'd0, Stall1}, 32'd0);
      chk($sformatf("rst Stall2 R%0d", 31 - a), {31'd0, Stall2}, 32'd0);
    end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    IssueReg      = 5'd5;
    ReadRegister1 = 5'd5;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post-rst RegWriteActive c%0d", c), {31'd0, RegWriteActive}, 32'd0);
      chk($sformatf("post-rst Stall1 c%0d", c), {31'd0, Stall1}, 32'd0);
      chk($sformatf("post-rst IssueReady c%0d", c), {31'd0, IssueReady}, 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
